// File: rtl/openhw_ahbsub_ram.sv
// -----------------------------------------------------------------------------
// openhw_ahbsub_ram
//
// AHB-Lite subordinate fronting a register-array RAM. It accepts single
// NONSEQ/SEQ transfers, derives byte-lane enables from HSIZE/HADDR, optionally
// stalls OKAY transfers for WAIT_STATES cycles, and can answer with the
// two-cycle ERROR response.
//
// Build option:
//   OPENHW_AHBSUB_ERR_EN  defined   : bad size, misaligned or out-of-range
//                                     transfers take the ERR1/ERR2 path.
//                         undefined : upper address bits alias, bad
//                                     size/alignment completes as OKAY with
//                                     the low offset bits ignored; HRESP = 0.
//
// Ports:
//   HCLK, HRESET   clock, asynchronous active-high reset
//   HSEL           subordinate select
//   HADDR          transfer address (PA_BITS)
//   HWRITE         1 = write, 0 = read
//   HSIZE          transfer size, log2 bytes
//   HTRANS         IDLE/BUSY/NONSEQ/SEQ
//   HWDATA         write data (data phase)
//   HREADY         bus-level ready
//   HREADYOUT      this subordinate ready
//   HRESP          0 OKAY, 1 ERROR
//   HRDATA         read data
// -----------------------------------------------------------------------------
module openhw_ahbsub_ram #(
    parameter int XLEN        = 64,
    parameter int PA_BITS     = 34,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic [PA_BITS-1:0] HADDR,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [1:0]         HTRANS,
    input  logic [XLEN-1:0]    HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [XLEN-1:0]    HRDATA
);

    localparam int NB     = XLEN / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
`ifdef OPENHW_AHBSUB_ERR_EN
        , S_ERR1
        , S_ERR2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NB-1:0]     be_q, be_d;
    logic [XLEN-1:0]   mem_q [DEPTH];

    // Lanes covered by a transfer of 2^size bytes starting at byte 'off'.
    function automatic logic [NB-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                input logic [2:0]       size);
        logic [NB-1:0] m;
        int unsigned   start;
        int unsigned   nbytes;
        m      = '0;
        start  = 32'(off);
        nbytes = 32'd1 << size;
        for (int unsigned i = 0; i < NB; i++) begin
            if (i >= start && i < start + nbytes) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Address-phase decode
    logic               accept;
    logic [IDX_W-1:0]   a_idx;
    logic [OFF_W-1:0]   a_off;
    logic               size_bad;
    logic [2:0]         eff_size;
    logic [OFF_W-1:0]   sz_mask;
    logic [NB-1:0]      a_be;
    logic               a_good;
    logic               wr_en;
    logic [XLEN-1:0]    fwd_word;
    logic               unused_bits;

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign a_idx    = HADDR[OFF_W +: IDX_W];
    assign a_off    = HADDR[OFF_W-1:0];
    assign size_bad = HSIZE > 3'(OFF_W);
    // Oversized transfers are clamped to a full word; the offset is forced
    // to the size alignment so the lane mask never runs past the word.
    assign eff_size = size_bad ? 3'(OFF_W) : HSIZE;
    assign sz_mask  = OFF_W'((32'd1 << eff_size) - 32'd1);
    assign a_be     = lane_mask(a_off & ~sz_mask, eff_size);

    assign unused_bits = ^{HADDR[PA_BITS-1:OFF_W+IDX_W], HTRANS[0]};

`ifdef OPENHW_AHBSUB_ERR_EN
    logic misalign;
    logic out_of_range;
    assign misalign     = |(a_off & sz_mask);
    assign out_of_range = |HADDR[PA_BITS-1:OFF_W+IDX_W];
    assign a_good       = ~(size_bad | misalign | out_of_range);
`else
    assign a_good       = 1'b1;
`endif

    assign wr_en = (state_q == S_DATA) && wr_q;

    // A read accepted on the same edge a write commits to the same word sees
    // the new lanes straight from HWDATA.
    always_comb begin
        fwd_word = mem_q[a_idx];
        if (wr_en && (idx_q == a_idx)) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) fwd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        be_d    = be_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
`ifdef OPENHW_AHBSUB_ERR_EN
            S_ERR1: state_d = S_ERR2;
`endif
            default: begin
                // IDLE, DATA and ERR2 all present HREADYOUT=1 and may take
                // the next address phase.
                state_d = S_IDLE;
                wr_d    = 1'b0;
                if (accept) begin
                    idx_d = a_idx;
                    be_d  = a_be;
                    wr_d  = HWRITE & a_good;
                    if (!a_good) begin
`ifdef OPENHW_AHBSUB_ERR_EN
                        state_d = S_ERR1;
`endif
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_DATA;
                    end
                    if (!HWRITE && a_good) rdata_d = fwd_word;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        idx_q <= idx_d;
        be_q  <= be_d;
    end

    // RAM write port: commits only at the end of a DATA cycle.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        case (state_q)
            S_WAIT:  HREADYOUT = 1'b0;
`ifdef OPENHW_AHBSUB_ERR_EN
            S_ERR1:  HREADYOUT = 1'b0;
`endif
            default: HREADYOUT = 1'b1;
        endcase
    end

`ifdef OPENHW_AHBSUB_ERR_EN
    assign HRESP = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
    assign HRESP = 1'b0;
`endif

    assign HRDATA = rdata_q;

endmodule

// File: tb/tb_openhw_ahbsub_ram.sv
`timescale 1ns/1ps
module tb_openhw_ahbsub_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel      [2];
    logic [33:0] haddr     [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [1:0]  htrans    [2];
    logic [63:0] hwdata    [2];
    logic        hready    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [63:0] hrdata    [2];

    int n_cmp = 0;
    int n_bad = 0;

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];

    // Zero-wait-state instance
    openhw_ahbsub_ram #(.XLEN(64), .PA_BITS(34), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]),
        .HWDATA(hwdata[0]), .HREADY(hready[0]), .HREADYOUT(hreadyout[0]),
        .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    // Three-wait-state instance
    openhw_ahbsub_ram #(.XLEN(64), .PA_BITS(34), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]),
        .HWDATA(hwdata[1]), .HREADY(hready[1]), .HREADYOUT(hreadyout[1]),
        .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_addr(input int d, input logic [33:0] a, input logic w, input logic [2:0] sz);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        haddr[d]  = a;
        hwrite[d] = w;
        hsize[d]  = sz;
    endtask

    task automatic put_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
    endtask

    // Bounded wait for HREADYOUT; returns the number of stalled cycles.
    task automatic wait_ready(input int d, output int stalls);
        stalls = 0;
        while (hreadyout[d] !== 1'b1 && stalls < 20) begin
            stalls++;
            tick();
        end
        if (stalls >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout dut%0d: HREADYOUT still %b after %0d cycles, need 1", d, hreadyout[d], stalls);
        end
    endtask

    task automatic do_write(input int d, input logic [33:0] a, input logic [2:0] sz, input logic [63:0] data);
        int s;
        put_addr(d, a, 1'b1, sz);
        tick();
        put_idle(d);
        hwdata[d] = data;
        wait_ready(d, s);
        tick();
    endtask

    task automatic do_read(input int d, input logic [33:0] a, output logic [63:0] data);
        int s;
        put_addr(d, a, 1'b0, 3'd3);
        tick();
        put_idle(d);
        wait_ready(d, s);
        data = hrdata[d];
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            put_idle(d);
            haddr[d]  = '0;
            hsize[d]  = 3'd3;
            hwdata[d] = '0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (hreadyout[d] !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout dut%0d: got %b need 1", d, hreadyout[d]); end
            n_cmp++;
            if (hresp[d] !== 1'b0) begin n_bad++; $display("FAIL reset_hresp dut%0d: got %b need 0", d, hresp[d]); end
            n_cmp++;
            if (hrdata[d] !== 64'h0) begin n_bad++; $display("FAIL reset_hrdata dut%0d: got %h need 0", d, hrdata[d]); end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        put_addr(0, 34'h10, 1'b1, 3'd3);
        tick();
        hwdata[0] = 64'h1122334455667788;
        put_addr(0, 34'h10, 1'b0, 3'd3);
        n_cmp++;
        if (hreadyout[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_ready: got %b need 1", hreadyout[0]); end
        tick();
        put_idle(0);
        n_cmp++;
        if (hrdata[0] !== 64'h1122334455667788) begin n_bad++; $display("FAIL b2b_forward: got %h need 1122334455667788", hrdata[0]); end
        n_cmp++;
        if (hreadyout[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_ready: got %b need 1", hreadyout[0]); end
        tick();
        do_read(0, 34'h10, r);
        n_cmp++;
        if (r !== 64'h1122334455667788) begin n_bad++; $display("FAIL b2b_readback: got %h need 1122334455667788", r); end
    endtask

    task automatic test_byte_lanes();
        logic [63:0] r;
        do_write(0, 34'h20, 3'd3, 64'h0);
        do_write(0, 34'h23, 3'd0, 64'hFFFFFFFF_ABFFFFFF);
        do_read(0, 34'h20, r);
        n_cmp++;
        if (r !== 64'h00000000_AB000000) begin n_bad++; $display("FAIL byte_write: got %h need 00000000ab000000", r); end
        do_write(0, 34'h26, 3'd1, 64'hBEEF1111_22223333);
        do_read(0, 34'h20, r);
        n_cmp++;
        if (r !== 64'hBEEF0000_AB000000) begin n_bad++; $display("FAIL half_write: got %h need beef0000ab000000", r); end
    endtask

    task automatic test_err();
        logic [63:0] r;
        do_write(0, 34'h0, 3'd3, 64'h0123456789ABCDEF);
        // Misaligned word write
        put_addr(0, 34'h2, 1'b1, 3'd2);
        tick();
        put_idle(0);
        hwdata[0] = 64'hFFFFFFFF_FFFFFFFF;
`ifdef OPENHW_AHBSUB_ERR_EN
        n_cmp++;
        if ({hreadyout[0], hresp[0]} !== 2'b01) begin n_bad++; $display("FAIL misalign_err1: got %b need 01", {hreadyout[0], hresp[0]}); end
        tick();
        n_cmp++;
        if ({hreadyout[0], hresp[0]} !== 2'b11) begin n_bad++; $display("FAIL misalign_err2: got %b need 11", {hreadyout[0], hresp[0]}); end
        tick();
        do_read(0, 34'h0, r);
        n_cmp++;
        if (r !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL misalign_ram: got %h need 0123456789abcdef", r); end
`else
        n_cmp++;
        if ({hreadyout[0], hresp[0]} !== 2'b10) begin n_bad++; $display("FAIL misalign_okay: got %b need 10", {hreadyout[0], hresp[0]}); end
        tick();
        do_read(0, 34'h0, r);
        n_cmp++;
        if (r !== 64'h01234567_FFFFFFFF) begin n_bad++; $display("FAIL misalign_ram: got %h need 01234567ffffffff", r); end
`endif
        // One word past the end of the RAM
        put_addr(0, 34'h800, 1'b1, 3'd3);
        tick();
        put_idle(0);
        hwdata[0] = 64'h5555555555555555;
`ifdef OPENHW_AHBSUB_ERR_EN
        n_cmp++;
        if ({hreadyout[0], hresp[0]} !== 2'b01) begin n_bad++; $display("FAIL oor_err1: got %b need 01", {hreadyout[0], hresp[0]}); end
        tick();
        n_cmp++;
        if ({hreadyout[0], hresp[0]} !== 2'b11) begin n_bad++; $display("FAIL oor_err2: got %b need 11", {hreadyout[0], hresp[0]}); end
        tick();
        do_read(0, 34'h0, r);
        n_cmp++;
        if (r !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL oor_ram: got %h need 0123456789abcdef", r); end
`else
        n_cmp++;
        if ({hreadyout[0], hresp[0]} !== 2'b10) begin n_bad++; $display("FAIL oor_okay: got %b need 10", {hreadyout[0], hresp[0]}); end
        tick();
        do_read(0, 34'h0, r);
        n_cmp++;
        if (r !== 64'h5555555555555555) begin n_bad++; $display("FAIL oor_alias: got %h need 5555555555555555", r); end
`endif
    endtask

    task automatic test_no_transfer();
        logic [63:0] r;
        hsel[0]   = 1'b0;
        htrans[0] = 2'b10;
        hwrite[0] = 1'b1;
        haddr[0]  = 34'h10;
        hsize[0]  = 3'd3;
        tick();
        hwdata[0] = 64'hFFFFFFFF_FFFFFFFF;
        n_cmp++;
        if ({hreadyout[0], hresp[0]} !== 2'b10) begin n_bad++; $display("FAIL nosel_ready: got %b need 10", {hreadyout[0], hresp[0]}); end
        hsel[0]   = 1'b1;
        htrans[0] = 2'b01;
        tick();
        n_cmp++;
        if ({hreadyout[0], hresp[0]} !== 2'b10) begin n_bad++; $display("FAIL busy_ready: got %b need 10", {hreadyout[0], hresp[0]}); end
        put_idle(0);
        tick();
        n_cmp++;
        if ({hreadyout[0], hresp[0]} !== 2'b10) begin n_bad++; $display("FAIL busy_after: got %b need 10", {hreadyout[0], hresp[0]}); end
        do_read(0, 34'h10, r);
        n_cmp++;
        if (r !== 64'h1122334455667788) begin n_bad++; $display("FAIL no_xfer_ram: got %h need 1122334455667788", r); end
    endtask

    task automatic test_wait_states();
        int s;
        put_addr(1, 34'h40, 1'b1, 3'd3);
        tick();
        put_idle(1);
        hwdata[1] = 64'hCAFEF00D12345678;
        wait_ready(1, s);
        n_cmp++;
        if (s !== 3) begin n_bad++; $display("FAIL wait_wr_stalls: got %0d need 3", s); end
        n_cmp++;
        if (hresp[1] !== 1'b0) begin n_bad++; $display("FAIL wait_wr_resp: got %b need 0", hresp[1]); end
        tick();
        put_addr(1, 34'h40, 1'b0, 3'd3);
        tick();
        put_idle(1);
        wait_ready(1, s);
        n_cmp++;
        if (s !== 3) begin n_bad++; $display("FAIL wait_rd_stalls: got %0d need 3", s); end
        n_cmp++;
        if (hrdata[1] !== 64'hCAFEF00D12345678) begin n_bad++; $display("FAIL wait_rd_data: got %h need cafef00d12345678", hrdata[1]); end
        tick();
        n_cmp++;
        if (hreadyout[1] !== 1'b1) begin n_bad++; $display("FAIL wait_idle_ready: got %b need 1", hreadyout[1]); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r;
        put_addr(1, 34'h40, 1'b1, 3'd3);
        tick();
        put_idle(1);
        hwdata[1] = 64'hDEADBEEFDEADBEEF;
        n_cmp++;
        if (hreadyout[1] !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_wait: got %b need 0", hreadyout[1]); end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({hreadyout[1], hresp[1]} !== 2'b10) begin n_bad++; $display("FAIL rstmid_resp: got %b need 10", {hreadyout[1], hresp[1]}); end
        n_cmp++;
        if (hrdata[1] !== 64'h0) begin n_bad++; $display("FAIL rstmid_hrdata: got %h need 0", hrdata[1]); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        do_read(1, 34'h40, r);
        n_cmp++;
        if (r !== 64'hCAFEF00D12345678) begin n_bad++; $display("FAIL rstmid_readback: got %h need cafef00d12345678", r); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_err();
        test_no_transfer();
        test_wait_states();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
